router_1xn_core: RTL and testbench
==================================

// Module: router_1xn_core
// PURPOSE
//  Packet router core: one byte-serial input, N output channels, each with its own FIFO.
//  Successor to the fixed 1x3 router; channel count, data width and FIFO depth are parameters.
//  Adds per-channel read timeout and invalid-address drop.
//  Sits between the write-side agent signals (data_in, pkt_valid, busy, error) and the
//  per-channel read-side signals (read_enb, vld_out, data_out) of the router interface.
// PARAMETERS
//  N_CH     3   number of output channels, 2..8; AW = $clog2(N_CH)
//  DATA_W   8   byte width; header length field = DATA_W-AW bits
//  DEPTH    16  entries per channel FIFO, power of 2, >= 4
//  TIMEOUT  30  idle cycles before soft-reset flush (only with ROUTER_SOFT_RST_EN)
// PORTS
//  clock      in   1             system clock, all logic on posedge
//  rst        in   1             synchronous reset, active-high
//  data_in    in   DATA_W        header / payload / parity byte
//  pkt_valid  in   1             data_in valid; byte accepted when pkt_valid && !busy
//  busy       out  1             input stall; source holds data_in while high
//  error      out  1             parity mismatch or invalid address on the last packet
//  read_enb   in   N_CH          per-channel pop request
//  vld_out    out  N_CH          per-channel FIFO non-empty
//  data_out   out  N_CH*DATA_W   channel i at [i*DATA_W +: DATA_W], registered
// BEHAVIOUR
//  Reset: clock; rst synchronous, active-high. When rst=1 at posedge: FSM->IDLE, all FIFOs
//   empty, data_out=0, vld_out=0, error=0, counters 0. busy=0 out of reset.
//   A reset mid-packet discards everything.
//  Packet: header {len[DATA_W-1:AW], addr[AW-1:0]}, then len payload bytes (len 0 legal),
//   then 1 parity byte. Total len+2 bytes.
//   Parity = XOR of header and all payload bytes.
//  FSM:
//   IDLE  -- accepted header, addr<N_CH    -> LOAD, store dest=addr, write header.
//   IDLE  -- accepted header, addr>=N_CH   -> DROP.
//   LOAD  writes payload to FIFO[dest]; after len payload bytes -> PARITY.
//   DROP  absorbs len+1 bytes, writes nothing, then -> CHECK with forced error.
//   PARITY  accepted byte written to FIFO[dest], compared to running parity -> CHECK.
//   CHECK  one cycle, busy=1; error <= mismatch/drop flag; -> IDLE.
//  Error timing: error is held until the next header is accepted, then cleared.
//  busy (combinational), high when any of:
//   - state==CHECK;
//   - state in {LOAD,PARITY} and FIFO[dest] full;
//   - state==IDLE, pkt_valid, valid addr, and FIFO[addr] full.
//  Full is evaluated before the same-cycle pop: no write-through on a full FIFO.
//  FIFO: DEPTH x DATA_W with a DEPTH+1-state count; pointers wrap modulo DEPTH.
//   vld_out[i] = count!=0.
//   read_enb[i] && vld_out[i]: data_out[i] <= head, pop; one-cycle latency, data_out holds
//    otherwise.
//   read_enb on an empty FIFO is ignored: no pop, data_out unchanged.
//   A push into an empty FIFO raises vld_out the next cycle.
//   Simultaneous push and pop on a non-full, non-empty FIFO leaves count unchanged.
// CONFIGURATION
//  ROUTER_SOFT_RST_EN defined:
//   - Per-channel counter increments while vld_out[i] && !read_enb[i]; it clears on a pop
//     or when empty.
//   - At count==TIMEOUT-1 the FIFO[i] pointers clear (vld_out[i]=0 next cycle) and the
//     counter clears.
//   - If the FSM is in LOAD/PARITY with dest==i, it moves to DROP for the remaining bytes;
//     error=1 in CHECK.
//  ROUTER_SOFT_RST_EN undefined: no counters; data held indefinitely; no timeout drops.
// TESTING
//  1. Header 8'h0D (len3, addr1), payload 11,22,33, parity 8'h0D^11^22^33 -> ch1 vld_out;
//     5 reads return 0D,11,22,33,parity; error stays 0.
//  2. Same packet with parity byte flipped -> all 5 bytes in ch1; error=1 one cycle after
//     the parity byte; error clears on the next header.
//  3. Header addr=3 (N_CH=3) len2 -> busy never blocks, no vld_out rise, error=1 after
//     4 bytes.
//  4. DEPTH=16, 20-byte packet to ch0, no reads -> busy=1 after 16 writes; one read drops
//     busy one cycle, next byte written.
//  5. ROUTER_SOFT_RST_EN, packet to ch2, read_enb low 30 cycles -> vld_out[2]=0 on cycle 31;
//     next packet routes normally.
//  6. rst=1 mid-LOAD -> next cycle all vld_out=0, error=0, busy=0; a fresh packet then
//     routes correctly.

Source files
------------

// File: rtl/router_1xn_core.sv
// router_1xn_core: byte-serial packet router, one input, N_CH output FIFOs.
// Header {len, addr}, len payload bytes, then XOR parity over header+payload.
// Ports: clock, rst (sync, active-high); data_in/pkt_valid/busy/error on the
//   write side; read_enb/vld_out/data_out (channel i at [i*DATA_W +: DATA_W])
//   on the read side.
// Option: define ROUTER_SOFT_RST_EN to flush a channel FIFO after TIMEOUT
//   cycles of unread data; an in-flight packet to it is then dropped.
module router_1xn_core #(
    parameter int N_CH    = 3,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 30
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     pkt_valid,
    output logic                     busy,
    output logic                     error,
    input  logic [N_CH-1:0]          read_enb,
    output logic [N_CH-1:0]          vld_out,
    output logic [N_CH*DATA_W-1:0]   data_out
);
    localparam int AW = $clog2(N_CH);
    localparam int LW = DATA_W - AW;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW:0] NCH_V = (AW + 1)'(N_CH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_PARITY = 3'd2;
    localparam logic [2:0] S_DROP   = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;

    logic [2:0]        state;
    logic [AW-1:0]     dest;
    logic [LW:0]       remain;
    logic [DATA_W-1:0] parity;
    logic              err_flag;

    logic [LW-1:0]     hdr_len;
    logic [AW-1:0]     hdr_addr;
    logic              addr_ok;
    logic [AW-1:0]     wr_ch;
    logic [N_CH-1:0]   full;
    logic [N_CH-1:0]   flush;
    logic              full_sel;
    logic              flush_dest;
    logic              accept;
    logic              wr_en;
    logic [LW:0]       drop_left;

    assign hdr_len  = data_in[DATA_W-1:AW];
    assign hdr_addr = data_in[AW-1:0];
    assign addr_ok  = {1'b0, hdr_addr} < NCH_V;
    assign wr_ch    = (state == S_IDLE) ? hdr_addr : dest;

    always_comb begin
        full_sel   = 1'b0;
        flush_dest = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (AW'(i) == wr_ch) full_sel = full[i];
            if (AW'(i) == dest)  flush_dest = flush[i];
        end
    end

    // Full is the pre-pop state: a pop in the same cycle never frees a slot.
    always_comb begin
        busy = 1'b0;
        case (state)
            S_CHECK:          busy = 1'b1;
            S_LOAD, S_PARITY: busy = full_sel;
            S_IDLE:           busy = pkt_valid && addr_ok && full_sel;
            default:          busy = 1'b0;
        endcase
    end

    assign accept = pkt_valid && !busy;
    assign wr_en  = accept && ((state == S_IDLE && addr_ok) ||
                               state == S_LOAD || state == S_PARITY);

    // Bytes still owed by the source when a flush aborts the current packet.
    always_comb begin
        drop_left = ((state == S_LOAD) ? remain + (LW + 1)'(1) : (LW + 1)'(1))
                    - (LW + 1)'(accept);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state    <= S_IDLE;
            dest     <= '0;
            remain   <= '0;
            parity   <= '0;
            err_flag <= 1'b0;
            error    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    error    <= 1'b0;
                    err_flag <= 1'b0;
                    parity   <= data_in;
                    if (addr_ok) begin
                        dest   <= hdr_addr;
                        remain <= {1'b0, hdr_len};
                        state  <= (hdr_len == '0) ? S_PARITY : S_LOAD;
                    end else begin
                        remain <= {1'b0, hdr_len} + (LW + 1)'(1);
                        state  <= S_DROP;
                    end
                end
                S_LOAD, S_PARITY: if (flush_dest) begin
                    err_flag <= 1'b1;
                    remain   <= drop_left;
                    state    <= (drop_left == '0) ? S_CHECK : S_DROP;
                end else if (accept) begin
                    if (state == S_LOAD) begin
                        parity <= parity ^ data_in;
                        remain <= remain - (LW + 1)'(1);
                        if (remain == (LW + 1)'(1)) state <= S_PARITY;
                    end else begin
                        err_flag <= (data_in != parity);
                        state    <= S_CHECK;
                    end
                end
                S_DROP: if (accept) begin
                    remain <= remain - (LW + 1)'(1);
                    if (remain == (LW + 1)'(1)) begin
                        err_flag <= 1'b1;
                        state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    error <= err_flag;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [DATA_W-1:0] mem [DEPTH];
        logic [PW-1:0]     wp;
        logic [PW-1:0]     rp;
        logic [CW-1:0]     cnt;
        logic [DATA_W-1:0] dout;
        logic              push;
        logic              pop;

        assign vld_out[g] = (cnt != '0);
        assign full[g]    = (cnt == CW'(DEPTH));
        assign push       = wr_en && (wr_ch == AW'(g)) && !flush[g];
        assign pop        = read_enb[g] && vld_out[g];
        assign data_out[g*DATA_W +: DATA_W] = dout;

`ifdef ROUTER_SOFT_RST_EN
        localparam int TW = $clog2(TIMEOUT + 1);
        logic [TW-1:0] tcnt;

        assign flush[g] = vld_out[g] && !read_enb[g] &&
                          (tcnt == TW'(TIMEOUT - 1));

        always_ff @(posedge clock) begin
            if (rst || !vld_out[g] || read_enb[g] || flush[g])
                tcnt <= '0;
            else
                tcnt <= tcnt + TW'(1);
        end
`else
        assign flush[g] = 1'b0;
`endif

        always_ff @(posedge clock) begin
            if (push) mem[wp] <= data_in;
        end

        always_ff @(posedge clock) begin
            if (rst) begin
                wp   <= '0;
                rp   <= '0;
                cnt  <= '0;
                dout <= '0;
            end else if (flush[g]) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                if (push) wp <= wp + PW'(1);
                if (pop) begin
                    dout <= mem[rp];
                    rp   <= rp + PW'(1);
                end
                case ({push, pop})
                    2'b10:   cnt <= cnt + CW'(1);
                    2'b01:   cnt <= cnt - CW'(1);
                    default: cnt <= cnt;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_router_1xn_core.sv
// tb_router_1xn_core: directed bench for router_1xn_core (N_CH=3, DATA_W=8,
// DEPTH=16, TIMEOUT=30); expected bytes are hand-computed.
module tb_router_1xn_core;
    logic        clock = 1'b0;
    logic        rst;
    logic [7:0]  data_in;
    logic        pkt_valid;
    logic        busy;
    logic        error;
    logic [2:0]  read_enb;
    logic [2:0]  vld_out;
    logic [23:0] data_out;

    int checks   = 0;
    int failures = 0;
    int stalls   = 0;

    router_1xn_core #(
        .N_CH(3), .DATA_W(8), .DEPTH(16), .TIMEOUT(30)
    ) dut (
        .clock(clock), .rst(rst), .data_in(data_in), .pkt_valid(pkt_valid),
        .busy(busy), .error(error), .read_enb(read_enb), .vld_out(vld_out),
        .data_out(data_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte is taken.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        data_in   = b;
        pkt_valid = 1'b1;
        #1;
        while (busy && n < 100) begin
            stalls++;
            n++;
            @(negedge clock);
            #1;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $error("FAIL send_timeout observed=busy expected=accept");
        end
        @(negedge clock);
        pkt_valid = 1'b0;
    endtask

    task automatic rd(input int ch, input logic [7:0] exp, input string tag);
        read_enb     = '0;
        read_enb[ch] = 1'b1;
        @(negedge clock);
        read_enb = '0;
        check(tag, data_out[ch*8 +: 8], exp);
    endtask

    initial begin
        logic [7:0] par;
        rst       = 1'b1;
        data_in   = '0;
        pkt_valid = 1'b0;
        read_enb  = '0;
        repeat (2) @(negedge clock);
        check("rst_vld", vld_out, 3'b000);
        check("rst_err", error, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_dout", data_out, 24'h0);
        rst = 1'b0;
        @(negedge clock);

        // Good packet to ch1.
        send(8'h0D); send(8'h11); send(8'h22); send(8'h33); send(8'h0D);
        check("t1_check_busy", busy, 1'b1);
        @(negedge clock);
        check("t1_vld", vld_out, 3'b010);
        check("t1_err", error, 1'b0);
        rd(1, 8'h0D, "t1_b0"); rd(1, 8'h11, "t1_b1"); rd(1, 8'h22, "t1_b2");
        rd(1, 8'h33, "t1_b3"); rd(1, 8'h0D, "t1_b4");
        check("t1_empty", vld_out, 3'b000);

        // Bad parity.
        send(8'h0D); send(8'h11); send(8'h22); send(8'h33); send(8'hF2);
        check("t2_err_in_check", error, 1'b0);
        @(negedge clock);
        check("t2_err", error, 1'b1);
        rd(1, 8'h0D, "t2_b0"); rd(1, 8'h11, "t2_b1"); rd(1, 8'h22, "t2_b2");
        rd(1, 8'h33, "t2_b3"); rd(1, 8'hF2, "t2_b4");
        send(8'h0D);
        check("t2_err_clr", error, 1'b0);
        send(8'h11); send(8'h22); send(8'h33); send(8'h0D);
        @(negedge clock);
        repeat (5) begin
            read_enb = 3'b010;
            @(negedge clock);
        end
        read_enb = '0;
        check("t2_drained", vld_out, 3'b000);

        // Invalid address 3, len 2.
        stalls = 0;
        send(8'h0B); send(8'hAA); send(8'hBB); send(8'hCC);
        check("t3_no_stall", stalls, 0);
        check("t3_no_vld", vld_out, 3'b000);
        @(negedge clock);
        check("t3_err", error, 1'b1);

        // Backpressure: len 18 to ch0, FIFO fills after 16 writes.
        send(8'h48);
        check("t4_err_clr", error, 1'b0);
        for (int k = 1; k <= 15; k++) send(8'(k));
        #1;
        check("t4_busy_full", busy, 1'b1);
        check("t4_vld", vld_out, 3'b001);
        data_in   = 8'd16;
        pkt_valid = 1'b1;
        read_enb  = 3'b001;
        #1;
        check("t4_busy_prepop", busy, 1'b1);
        @(negedge clock);
        read_enb = '0;
        #1;
        check("t4_hdr", data_out[7:0], 8'h48);
        check("t4_busy_drop", busy, 1'b0);
        @(negedge clock);
        #1;
        check("t4_busy_again", busy, 1'b1);
        pkt_valid = 1'b0;
        @(negedge clock);
        for (int k = 1; k <= 16; k++) rd(0, 8'(k), "t4_payload");
        check("t4_empty_mid", vld_out, 3'b000);
        par = 8'h48;
        for (int k = 1; k <= 18; k++) par = par ^ 8'(k);
        send(8'd17); send(8'd18); send(par);
        @(negedge clock);
        check("t4_err", error, 1'b0);
        rd(0, 8'd17, "t4_b17"); rd(0, 8'd18, "t4_b18"); rd(0, par, "t4_par");

        // Unread data on ch2.
        send(8'h06); send(8'h5A); send(8'h5C);
        repeat (20) @(negedge clock);
        check("t5_vld_held", vld_out, 3'b100);
`ifdef ROUTER_SOFT_RST_EN
        repeat (15) @(negedge clock);
        check("t5_flushed", vld_out, 3'b000);
        check("t5_err", error, 1'b0);
        send(8'h06); send(8'h5A); send(8'h5C);
        @(negedge clock);
        rd(2, 8'h06, "t5_b0"); rd(2, 8'h5A, "t5_b1"); rd(2, 8'h5C, "t5_b2");
`else
        repeat (40) @(negedge clock);
        check("t5_still_held", vld_out, 3'b100);
        rd(2, 8'h06, "t5_b0"); rd(2, 8'h5A, "t5_b1"); rd(2, 8'h5C, "t5_b2");
`endif

        // Reset mid-LOAD.
        send(8'h0D); send(8'h11);
        check("t6_vld_pre", vld_out, 3'b010);
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        check("t6_vld", vld_out, 3'b000);
        check("t6_err", error, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_dout", data_out, 24'h0);
        rd(0, 8'h00, "t6_empty_read");
        check("t6_empty_vld", vld_out, 3'b000);
        send(8'h0D); send(8'h11); send(8'h22); send(8'h33); send(8'h0D);
        @(negedge clock);
        check("t6_err_after", error, 1'b0);
        rd(1, 8'h0D, "t6_b0"); rd(1, 8'h11, "t6_b1"); rd(1, 8'h22, "t6_b2");
        rd(1, 8'h33, "t6_b3"); rd(1, 8'h0D, "t6_b4");
        check("t6_drained", vld_out, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
